// File: rtl/alu_cmd_ctrl.sv
// Byte-stream command sequencer for the ALU: parses CC/DD frames, gates and starts the ALU, streams the result LSB byte first.
// Optional macro ALU_TIMEOUT_EN bounds the ALU_WAIT state to TIMEOUT cycles and substitutes an all-ones result.
module alu_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int FUN_WIDTH  = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  ALU_EN,
    output logic                  GATE_EN,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  ALU_OUT_VLD,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_READY,
    output logic                  BUSY,
    output logic                  CMD_ERR
);

    localparam int NBYTES = OUT_WIDTH / DATA_WIDTH;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [DATA_WIDTH-1:0] CMD_FULL  = DATA_WIDTH'('hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_REUSE = DATA_WIDTH'('hDD);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_A, S_GET_B, S_GET_FUN,
        S_GATE_ON, S_ALU_REQ, S_ALU_WAIT, S_TX_SEND
    } state_e;

    state_e                               state_q, state_d;
    logic [DATA_WIDTH-1:0]                a_q, a_d, b_q, b_d;
    logic [FUN_WIDTH-1:0]                 fun_q, fun_d;
    logic [NBYTES-1:0][DATA_WIDTH-1:0]    res_q, res_d;
    logic [CW-1:0]                        cnt_q, cnt_d;
    logic                                 err_q, err_d;

`ifdef ALU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fun_d   = fun_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`ifdef ALU_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_FULL)       state_d = S_GET_A;
                    else if (RX_P_DATA == CMD_REUSE) state_d = S_GET_FUN;
                    else                             err_d   = 1'b1;
                end
            end
            S_GET_A: begin
                if (RX_D_VLD) begin
                    a_d     = RX_P_DATA;
                    state_d = S_GET_B;
                end
            end
            S_GET_B: begin
                if (RX_D_VLD) begin
                    b_d     = RX_P_DATA;
                    state_d = S_GET_FUN;
                end
            end
            S_GET_FUN: begin
                if (RX_D_VLD) begin
                    fun_d   = RX_P_DATA[FUN_WIDTH-1:0];
                    state_d = S_GATE_ON;
                end
            end
            // One cycle of gated clock before the enable so the ALU sees a clean edge.
            S_GATE_ON: begin
                err_d   = RX_D_VLD;
                state_d = S_ALU_REQ;
            end
            S_ALU_REQ: begin
                err_d   = RX_D_VLD;
                state_d = S_ALU_WAIT;
`ifdef ALU_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_ALU_WAIT: begin
                err_d = RX_D_VLD;
                if (ALU_OUT_VLD) begin
                    res_d   = ALU_OUT;
                    cnt_d   = '0;
                    state_d = S_TX_SEND;
                end
`ifdef ALU_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    res_d   = '1;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_TX_SEND;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            // The cycle of the last transfer still counts as busy for incoming bytes.
            S_TX_SEND: begin
                err_d = RX_D_VLD;
                if (TX_READY) begin
                    if (cnt_q == CW'(NBYTES - 1)) state_d = S_IDLE;
                    else                          cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            fun_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef ALU_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fun_q   <= fun_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef ALU_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign ALU_A     = a_q;
    assign ALU_B     = b_q;
    assign ALU_FUN   = fun_q;
    assign ALU_EN    = (state_q == S_ALU_REQ);
    assign GATE_EN   = (state_q == S_GATE_ON) || (state_q == S_ALU_REQ) || (state_q == S_ALU_WAIT);
    assign TX_D_VLD  = (state_q == S_TX_SEND);
    assign TX_P_DATA = TX_D_VLD ? res_q[cnt_q] : '0;
    assign BUSY      = (state_q != S_IDLE);
    assign CMD_ERR   = err_q;

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
- Byte-stream command sequencer that owns the ALU datapath.
- Parses command frames from the RX-side byte interface and loads operand/function registers.
- Gates the ALU clock and pulses the ALU enable, waits for the ALU valid, then returns the result as bytes over a ready/valid TX interface.
- Sits between the RX/TX synchroniser domain and the ALU in the system clock domain.

Parameters:
- DATA_WIDTH, 8, width of RX/TX bytes and of ALU operands A/B.
- OUT_WIDTH, 16, ALU result width; must be a multiple of DATA_WIDTH, max 4*DATA_WIDTH.
- FUN_WIDTH, 4, ALU function code width (low bits of the FUN byte).
- TIMEOUT, 15, ALU_WAIT cycle limit; used only when ALU_TIMEOUT_EN is defined.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- RX_P_DATA  in  DATA_WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA is valid.
- ALU_A  out  DATA_WIDTH  operand A register.
- ALU_B  out  DATA_WIDTH  operand B register.
- ALU_FUN  out  FUN_WIDTH  function register.
- ALU_EN  out  1  one-cycle ALU start.
- GATE_EN  out  1  ALU clock-gate enable.
- ALU_OUT  in  OUT_WIDTH  ALU result.
- ALU_OUT_VLD  in  1  ALU result valid strobe.
- TX_P_DATA  out  DATA_WIDTH  result byte.
- TX_D_VLD  out  1  TX byte valid.
- TX_READY  in  1  TX side accepts the byte.
- BUSY  out  1  high when state is not IDLE.
- CMD_ERR  out  1  one-cycle error pulse.

Behaviour:
- Reset (RST=0, async):
  - state=IDLE.
  - ALU_A, ALU_B, ALU_FUN, result register and byte counter cleared to 0.
  - All outputs 0.
- Commands (first byte of a frame, accepted in IDLE):
  - 0xCC: full frame, followed by A, B, FUN.
  - 0xDD: reuse frame, followed by FUN only; A/B keep their previous values.
  - Any other byte in IDLE: dropped, CMD_ERR pulses next cycle, state stays IDLE.
- States and transitions:
  - IDLE -> GET_A (0xCC) or GET_FUN (0xDD).
  - GET_A -> GET_B: on RX_D_VLD, ALU_A <= RX_P_DATA.
  - GET_B -> GET_FUN: on RX_D_VLD, ALU_B <= RX_P_DATA.
  - GET_FUN -> GATE_ON: on RX_D_VLD, ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0]; upper bits ignored.
  - GATE_ON: GATE_EN=1, ALU_EN=0, exactly 1 cycle, so the gated clock is running before the enable -> ALU_REQ.
  - ALU_REQ: GATE_EN=1, ALU_EN=1, exactly 1 cycle -> ALU_WAIT.
  - ALU_WAIT: GATE_EN=1; on ALU_OUT_VLD, result register <= ALU_OUT, byte counter <= 0 -> TX_SEND. ALU_OUT_VLD already high in ALU_REQ is ignored.
  - TX_SEND: TX_D_VLD=1; TX_P_DATA = result byte[counter], LSB byte first. Data held stable until TX_READY=1 in the same cycle as TX_D_VLD. On the transfer, counter increments; after byte OUT_WIDTH/DATA_WIDTH-1 transfers -> IDLE with TX_D_VLD=0 that cycle. TX_D_VLD stays high between consecutive bytes (back-to-back transfers allowed).
- GATE_EN is 0 in every other state; ALU_EN is high only in ALU_REQ.
- Latency: last frame byte strobe -> ALU_EN high 2 cycles later. ALU_OUT_VLD -> first TX_D_VLD on the next cycle.
- Bytes arriving outside IDLE/GET_* states (GATE_ON..TX_SEND):
  - dropped, CMD_ERR pulses; the operation in progress is unaffected.
  - Operand/function registers never change outside GET_* states.
- An RX_D_VLD in the same cycle the FSM returns from TX_SEND to IDLE is treated as busy: dropped with CMD_ERR.
- Reset asserted mid-operation: immediate return to the reset values above; a partially sent result is abandoned.
- CMD_ERR is registered, one cycle wide per offending byte.

Optional Feature:
- Macro ALU_TIMEOUT_EN.
- Defined: a counter runs in ALU_WAIT. If TIMEOUT cycles pass without ALU_OUT_VLD:
  - result register <= all ones, CMD_ERR pulses, -> TX_SEND.
  - ALU_OUT_VLD on exactly the timeout cycle wins (real result is sent, no error).
  - Counter is cleared on entry to ALU_WAIT.
- Not defined: no counter; ALU_WAIT holds indefinitely.

Test Plan:
- Full frame: RX 0xCC,0x12,0x34,0x00; ALU model returns 0x0046 one cycle after ALU_EN -> GATE_EN one cycle before ALU_EN; ALU_A=0x12, ALU_B=0x34, ALU_FUN=0x0; TX bytes 0x46 then 0x00; BUSY low afterwards.
- Reuse frame: after the previous test, RX 0xDD,0x01; model returns 0x0022 -> ALU_A=0x12, ALU_B=0x34 unchanged, ALU_FUN=0x1; TX 0x22,0x00.
- TX backpressure: TX_READY low for 5 cycles during byte 0 -> TX_P_DATA=0x46 held stable with TX_D_VLD high; exactly 2 transfers total.
- Errors: RX 0x55 in IDLE -> CMD_ERR pulse, state IDLE. RX byte 0xAA during ALU_WAIT -> CMD_ERR pulse, result still sent, operands unchanged.
- Reset mid-TX: RST low after the first byte transfers -> all outputs 0 asynchronously; a new 0xCC frame after release works normally.
- With ALU_TIMEOUT_EN, TIMEOUT=15, model never asserts valid -> after 15 cycles in ALU_WAIT, CMD_ERR pulses and TX sends 0xFF,0xFF.
